// File: rtl/calc_input_ctrl.sv
// Front-end sequencer for the board calculator: debounces the operand buttons,
// latches the switch operands, runs the start/done handshake and drives the scanner.
module calc_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic        CLK100MHZ,
   input  logic        CPU_RESETN,
   input  logic        BTNL,
   input  logic        BTNR,
   input  logic [15:0] SW,
   output logic        alu_start,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   input  logic        alu_done,
   input  logic [31:0] alu_result,
   output logic [31:0] disp_value,
   output logic [7:0]  disp_mask,
   output logic        busy
);

   localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int TOW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [DBW-1:0] DBC_LAST = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT_CYCLES - 1);
   localparam logic [TOW-1:0] TO_MAX   = {TOW{1'b1}};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GOT_A = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      SHOW  = 3'd4,
      ERR   = 3'd5
   } state_t;

   // index 0 = left button, index 1 = right button
   logic [1:0]     btn_raw_s;
   logic [1:0]     sync1_r;
   logic [1:0]     sync2_r;
   logic [1:0]     stable_r;
   logic [1:0]     press_r;
   logic [DBW-1:0] dbc_cnt_r [2];

   state_t         state_r;
   state_t         state_nx_s;
   logic [15:0]    alu_a_r;
   logic [15:0]    alu_a_nx_s;
   logic [15:0]    alu_b_r;
   logic [15:0]    alu_b_nx_s;
   logic [31:0]    result_r;
   logic [31:0]    result_nx_s;
   logic [TOW-1:0] tcnt_r;
   logic [TOW-1:0] tcnt_nx_s;
   logic           alu_start_r;
   logic           busy_r;
   logic [31:0]    disp_value_r;
   logic [7:0]     disp_mask_r;
   logic           press_l_s;
   logic           press_r_s;

   assign btn_raw_s = {BTNR, BTNL};
   assign press_l_s = press_r[0];
   assign press_r_s = press_r[1];

   // Synchronise, then accept a new level only after it has differed from the
   // stable level for DEBOUNCE_CYCLES consecutive clocks; any return clears it.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         sync1_r  <= 2'b00;
         sync2_r  <= 2'b00;
         stable_r <= 2'b00;
         press_r  <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            dbc_cnt_r[i] <= '0;
         end
      end else begin
         sync1_r <= btn_raw_s;
         sync2_r <= sync1_r;
         for (int i = 0; i < 2; i++) begin
            press_r[i] <= 1'b0;
            if (sync2_r[i] == stable_r[i]) begin
               dbc_cnt_r[i] <= '0;
            end else if (dbc_cnt_r[i] == DBC_LAST) begin
               stable_r[i]  <= sync2_r[i];
               dbc_cnt_r[i] <= '0;
               press_r[i]   <= sync2_r[i];
            end else begin
               dbc_cnt_r[i] <= dbc_cnt_r[i] + DBW'(1);
            end
         end
      end
   end

   // Next-state and next-datapath logic of the sequencer.
   always_comb begin
      state_nx_s  = state_r;
      alu_a_nx_s  = alu_a_r;
      alu_b_nx_s  = alu_b_r;
      result_nx_s = result_r;
      tcnt_nx_s   = tcnt_r;
      case (state_r)
         IDLE, SHOW, ERR: begin
            if (press_l_s) begin
               alu_a_nx_s = SW;
               state_nx_s = GOT_A;
            end else begin
               state_nx_s = state_r;
            end
         end
         GOT_A: begin
            if (press_l_s) begin
               alu_a_nx_s = SW;
            end else if (press_r_s) begin
               alu_b_nx_s = SW;
               state_nx_s = START;
            end else begin
               state_nx_s = GOT_A;
            end
         end
         START: begin
            state_nx_s = WAIT;
            tcnt_nx_s  = '0;
         end
         WAIT: begin
            if (alu_done) begin
               result_nx_s = alu_result;
               state_nx_s  = SHOW;
            end else if (tcnt_r == TO_LAST) begin
               state_nx_s = ERR;
            end else if (tcnt_r != TO_MAX) begin
               tcnt_nx_s = tcnt_r + TOW'(1);
            end else begin
               tcnt_nx_s = tcnt_r;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // Sequencer state, operand/result registers and handshake outputs.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_r     <= IDLE;
         alu_a_r     <= 16'h0000;
         alu_b_r     <= 16'h0000;
         result_r    <= 32'h0000_0000;
         tcnt_r      <= '0;
         alu_start_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         alu_a_r     <= alu_a_nx_s;
         alu_b_r     <= alu_b_nx_s;
         result_r    <= result_nx_s;
         tcnt_r      <= tcnt_nx_s;
         alu_start_r <= (state_nx_s == START);
         busy_r      <= (state_nx_s == START) || (state_nx_s == WAIT);
      end
   end

   // Scanner value and digit enables, one clock behind the sequencer.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         disp_value_r <= 32'h0000_0000;
         disp_mask_r  <= 8'h00;
      end else begin
         case (state_r)
            IDLE: begin
               disp_value_r <= {16'h0000, SW};
               disp_mask_r  <= 8'h0F;
            end
            GOT_A: begin
               disp_value_r <= {alu_a_r, SW};
               disp_mask_r  <= 8'hFF;
            end
            START, WAIT: begin
               disp_value_r <= {alu_a_r, alu_b_r};
               disp_mask_r  <= 8'hFF;
            end
            SHOW: begin
               disp_value_r <= result_r;
               disp_mask_r  <= 8'hFF;
            end
            ERR: begin
               disp_value_r <= 32'hEEEE_EEEE;
               disp_mask_r  <= 8'hFF;
            end
            default: begin
               disp_value_r <= 32'h0000_0000;
               disp_mask_r  <= 8'h00;
            end
         endcase
      end
   end

   assign alu_start  = alu_start_r;
   assign alu_a      = alu_a_r;
   assign alu_b      = alu_b_r;
   assign busy       = busy_r;
   assign disp_value = disp_value_r;
   assign disp_mask  = disp_mask_r;

endmodule
